shift_seq_ctrl: RTL

- Upstream sequencer for the universal shift register `ulv_shift_reg`, whose ports are clk, reset, ctrl[1:0], d[N-1:0] and q[N-1:0].
- Accepts a parallel word over a valid/ready handshake.
- Drives the register's ctrl and d to load the word, then shifts it out over exactly N cycles in the selected direction.
- Presents the serialized bit stream, taken from the register's q, as ser_out/ser_valid. Pulses done at the end of each transfer.

---
 rtl/shift_seq_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : shift_seq_ctrl
//  Description : Upstream sequencer for a universal shift register. Accepts a
//                parallel word over valid/ready, loads it into the register,
//                then shifts it out over N cycles MSB- or LSB-first and
//                presents the serial stream on ser_out/ser_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_seq_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,        // synchronous, active-low
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [N-1:0] data_in,
  input  logic         dir,          // 0 = MSB first, 1 = LSB first
  input  logic         abort,
  output logic [1:0]   sr_ctrl,
  output logic [N-1:0] sr_d,
  input  logic [N-1:0] sr_q,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         busy,
  output logic         done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  localparam logic [1:0] CTRL_HOLD  = 2'b00;
  localparam logic [1:0] CTRL_LEFT  = 2'b01;
  localparam logic [1:0] CTRL_RIGHT = 2'b10;
  localparam logic [1:0] CTRL_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  data_q,  data_d;
  logic          dir_q,   dir_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  // Only the two end bits of the register feed the serial output.
  logic unused_sr_q;
  assign unused_sr_q = ^sr_q;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: capture on handshake, abort returns to IDLE from LOAD/SHIFT.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_valid && !abort) begin
          data_d  = data_in;
          dir_d   = dir;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = abort ? ST_IDLE : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from registered state; only start_ready and ser_out see inputs.
  always_comb begin
    start_ready = 1'b0;
    sr_ctrl     = CTRL_HOLD;
    sr_d        = '0;
    ser_out     = 1'b0;
    ser_valid   = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy        = 1'b0;
        start_ready = !abort;
      end
      ST_LOAD: begin
        sr_ctrl = CTRL_LOAD;
        sr_d    = data_q;
      end
      ST_SHIFT: begin
        sr_ctrl   = dir_q ? CTRL_RIGHT : CTRL_LEFT;
        ser_valid = 1'b1;
        ser_out   = dir_q ? sr_q[0] : sr_q[N-1];
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire
